// File: rtl/tl_pkg.sv
// tl_pkg: phase, lamp and fault encodings shared by the lamp controller and monitor.
package tl_pkg;
  typedef enum logic [1:0] {PH_R = 2'd0, PH_G = 2'd1, PH_Y = 2'd2, PH_NONE = 2'd3} phase_t;
  typedef enum logic [2:0] {F_NONE = 3'd0, F_ILLEGAL = 3'd1, F_SEQ = 3'd2, F_SHORT = 3'd3, F_STUCK = 3'd4} fault_t;
  typedef enum logic [1:0] {ST_IDLE, ST_LOCKED, ST_FAULT} state_t;
  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_G = 3'b010;
  localparam logic [2:0] LAMP_Y = 3'b001;
  function automatic phase_t next_phase(phase_t p);
    return p == PH_R ? PH_G : p == PH_G ? PH_Y : p == PH_Y ? PH_R : PH_NONE;
  endfunction
endpackage

// File: rtl/tl_lamp_monitor_if.sv
// tl_lamp_monitor_if: lamp bus plus monitor status; master drives the lamps, slave is the monitor.
interface tl_lamp_monitor_if #(parameter int CNT_W = 8);
  logic [2:0] rgb;
  logic clr_fault;
  logic [1:0] phase;
  logic locked;
  logic phase_chg;
  logic [CNT_W-1:0] dwell;
  logic [CNT_W-1:0] cycle_cnt;
  logic fault;
  logic [2:0] fault_code;
  modport master(output rgb, clr_fault, input phase, locked, phase_chg, dwell, cycle_cnt, fault, fault_code);
  modport slave(input rgb, clr_fault, output phase, locked, phase_chg, dwell, cycle_cnt, fault, fault_code);
endinterface

// File: rtl/tl_lamp_decode.sv
// tl_lamp_decode: one-hot lamp pattern to phase; anything else is flagged invalid.
module tl_lamp_decode
  import tl_pkg::*;
(
  input  logic [2:0] rgb,
  output logic       valid,
  output phase_t     phase
);
  always_comb begin
    phase = rgb == LAMP_R ? PH_R : rgb == LAMP_G ? PH_G : rgb == LAMP_Y ? PH_Y : PH_NONE;
    valid = phase != PH_NONE;
  end
endmodule

// File: rtl/tl_lamp_monitor.sv
// tl_lamp_monitor: checks lamp legality, R->G->Y->R order and dwell bounds; latches first fault.
module tl_lamp_monitor
  import tl_pkg::*;
#(
  parameter int MIN_DWELL = 1,
  parameter int MAX_DWELL = 255,
  parameter int CNT_W     = 8
) (
  input logic clk,
  input logic rst,
  tl_lamp_monitor_if.slave bus
);
  logic valid;
  phase_t dec;
  tl_lamp_decode u_dec (.rgb(bus.rgb), .valid(valid), .phase(dec));
  state_t state_q, state_d;
  phase_t phase_q, phase_d;
  fault_t code_q, code_d, lock_code;
  logic [CNT_W-1:0] dwell_q, dwell_d, cnt_q, cnt_d;
  logic chg_q, chg_d, is_same, is_next;
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    code_d = code_q;
    dwell_d = dwell_q;
    cnt_d = cnt_q;
    chg_d = 1'b0;
    is_same = dec == phase_q;
    is_next = dec == next_phase(phase_q);
    // priority: illegal, out of order, too short, held too long
    lock_code = !valid ? F_ILLEGAL
              : !(is_same || is_next) ? F_SEQ
              : is_next && dwell_q < CNT_W'(MIN_DWELL) ? F_SHORT
              : is_same && dwell_q == CNT_W'(MAX_DWELL) ? F_STUCK
              : F_NONE;
    case (state_q)
      ST_IDLE: begin
        if (!valid) begin
          state_d = ST_FAULT;
          code_d = F_ILLEGAL;
        end else if (dec == PH_R) begin
          state_d = ST_LOCKED;
          phase_d = PH_R;
          dwell_d = CNT_W'(1);
        end
      end
      ST_LOCKED: begin
        if (lock_code != F_NONE) begin
          state_d = ST_FAULT;
          code_d = lock_code;
          phase_d = PH_NONE;
        end else if (is_next) begin
          phase_d = dec;
          dwell_d = CNT_W'(1);
          chg_d = 1'b1;
          cnt_d = dec == PH_R && !(&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
        end else begin
          dwell_d = dwell_q + CNT_W'(1);
        end
      end
      ST_FAULT: begin
        if (bus.clr_fault) begin
          state_d = ST_IDLE;
          code_d = F_NONE;
          dwell_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      phase_q <= PH_NONE;
      code_q <= F_NONE;
      dwell_q <= '0;
      cnt_q <= '0;
      chg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      code_q <= code_d;
      dwell_q <= dwell_d;
      cnt_q <= cnt_d;
      chg_q <= chg_d;
    end
  end
  assign bus.phase = phase_q;
  assign bus.locked = state_q == ST_LOCKED;
  assign bus.phase_chg = chg_q;
  assign bus.dwell = dwell_q;
  assign bus.cycle_cnt = cnt_q;
  assign bus.fault = state_q == ST_FAULT;
  assign bus.fault_code = code_q;
endmodule

// File: tb/tb_tl_lamp_monitor.sv
// tb_tl_lamp_monitor: default and tight-dwell monitors driven in parallel, compared to a cycle model.
module tb_tl_lamp_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] rgb = 3'b000;
  logic clr = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  tl_lamp_monitor_if #(.CNT_W(8)) ifa ();
  tl_lamp_monitor_if #(.CNT_W(8)) ifb ();
  assign ifa.rgb = rgb;
  assign ifb.rgb = rgb;
  assign ifa.clr_fault = clr;
  assign ifb.clr_fault = clr;
  tl_lamp_monitor u_a (.clk(clk), .rst(rst), .bus(ifa));
  tl_lamp_monitor #(.MIN_DWELL(3), .MAX_DWELL(4), .CNT_W(8)) u_b (.clk(clk), .rst(rst), .bus(ifb));
  logic [1:0] o_phase [2];
  logic o_locked [2], o_chg [2], o_fault [2];
  logic [7:0] o_dwell [2], o_cnt [2];
  logic [2:0] o_code [2];
  assign o_phase = '{ifa.phase, ifb.phase};
  assign o_locked = '{ifa.locked, ifb.locked};
  assign o_chg = '{ifa.phase_chg, ifb.phase_chg};
  assign o_fault = '{ifa.fault, ifb.fault};
  assign o_dwell = '{ifa.dwell, ifb.dwell};
  assign o_cnt = '{ifa.cycle_cnt, ifb.cycle_cnt};
  assign o_code = '{ifa.fault_code, ifb.fault_code};
  // model state: mode 0 idle, 1 locked, 2 faulted; ph is 0..2 while locked
  int m_mode [2], m_ph [2], m_dw [2], m_cnt [2], m_code [2], m_chg [2];
  int mins [2] = '{1, 3};
  int maxs [2] = '{255, 4};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic logic [2:0] lamp(input int p);
    logic [2:0] r;
    r = 3'b100 >> (p % 3);
    return r;
  endfunction
  task automatic trip(input int d, input int code);
    m_mode[d] = 2;
    m_code[d] = code;
  endtask
  task automatic model(input int d, input logic [2:0] r, input bit c, input bit rs);
    int p;
    p = r == 3'b100 ? 0 : r == 3'b010 ? 1 : r == 3'b001 ? 2 : -1;
    m_chg[d] = 0;
    if (rs) begin
      m_mode[d] = 0; m_dw[d] = 0; m_cnt[d] = 0; m_code[d] = 0;
    end else if (m_mode[d] == 2) begin
      if (c) begin m_mode[d] = 0; m_code[d] = 0; m_dw[d] = 0; end
    end else if (m_mode[d] == 0) begin
      if (p < 0) trip(d, 1);
      else if (p == 0) begin m_mode[d] = 1; m_ph[d] = 0; m_dw[d] = 1; end
    end else if (p < 0) trip(d, 1);
    else if (p == m_ph[d]) begin
      if (m_dw[d] == maxs[d]) trip(d, 4);
      else m_dw[d]++;
    end else if (p == (m_ph[d] + 1) % 3) begin
      if (m_dw[d] < mins[d]) trip(d, 3);
      else begin
        m_ph[d] = p; m_dw[d] = 1; m_chg[d] = 1;
        if (p == 0 && m_cnt[d] < 255) m_cnt[d]++;
      end
    end else trip(d, 2);
  endtask
  task automatic step(input logic [2:0] r, input bit c = 1'b0, input bit rs = 1'b0);
    rgb = r; clr = c; rst = rs;
    @(posedge clk);
    for (int d = 0; d < 2; d++) model(d, r, c, rs);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("phase[%0d]", d), o_phase[d], m_mode[d] == 1 ? m_ph[d] : 3);
      chk($sformatf("locked[%0d]", d), o_locked[d], m_mode[d] == 1);
      chk($sformatf("phase_chg[%0d]", d), o_chg[d], m_chg[d]);
      chk($sformatf("dwell[%0d]", d), o_dwell[d], m_dw[d]);
      chk($sformatf("cycle_cnt[%0d]", d), o_cnt[d], m_cnt[d]);
      chk($sformatf("fault[%0d]", d), o_fault[d], m_mode[d] == 2);
      chk($sformatf("fault_code[%0d]", d), o_code[d], m_code[d]);
    end
  endtask
  initial begin
    step(3'b000, 0, 1);
    step(3'b000, 0, 1);
    chk("rst_phase", ifa.phase, 3);
    chk("rst_dwell", ifa.dwell, 0);
    // basic rotation
    step(3'b100);
    chk("lock_first_edge", ifa.locked, 1);
    step(3'b010);
    chk("chg_g", ifa.phase_chg, 1);
    step(3'b001);
    step(3'b100);
    chk("rot_phase", ifa.phase, 0);
    chk("rot_cnt", ifa.cycle_cnt, 1);
    chk("rot_nofault", ifa.fault, 0);
    // green before red is ignored
    step(3'b000, 0, 1);
    repeat (3) step(3'b010);
    chk("idle_g_phase", ifa.phase, 3);
    chk("idle_g_fault", ifa.fault, 0);
    step(3'b100);
    chk("idle_relock", ifa.locked, 1);
    // illegal pattern, then clear keeps cycle count
    step(3'b010); step(3'b001); step(3'b100);
    step(3'b110);
    chk("ill_code", ifa.fault_code, 1);
    chk("ill_phase", ifa.phase, 3);
    step(3'b110, 1);
    chk("clr_code", ifa.fault_code, 0);
    chk("clr_cnt", ifa.cycle_cnt, 1);
    chk("clr_locked", ifa.locked, 0);
    // out of order
    step(3'b000, 0, 1);
    step(3'b100); step(3'b001);
    chk("seq_code", ifa.fault_code, 2);
    // too short on the tight monitor
    step(3'b000, 0, 1);
    step(3'b100); step(3'b100); step(3'b010);
    chk("short_code", ifb.fault_code, 3);
    // held too long on the tight monitor
    step(3'b000, 0, 1);
    repeat (4) step(3'b100);
    chk("max_ok", ifb.fault, 0);
    step(3'b100);
    chk("stuck_code", ifb.fault_code, 4);
    chk("stuck_dwell", ifb.dwell, 4);
    // reset mid-green
    step(3'b000, 0, 1);
    repeat (5) begin step(3'b100); step(3'b010); step(3'b001); end
    step(3'b100); step(3'b010); step(3'b010);
    chk("pre_rst_cnt", ifa.cycle_cnt, 5);
    chk("pre_rst_dwell", ifa.dwell, 2);
    step(3'b010, 1, 1);
    chk("mid_rst_cnt", ifa.cycle_cnt, 0);
    chk("mid_rst_phase", ifa.phase, 3);
    step(3'b010);
    chk("rst_needs_red", ifa.locked, 0);
    step(3'b100);
    chk("rst_relock", ifa.locked, 1);
    // randomized traffic biased toward plausible sequences
    for (int i = 0; i < 3000; i++) begin
      int d, k, ph;
      logic [2:0] r;
      logic [2:0] rr;
      d = int'($urandom_range(0, 1));
      k = int'($urandom_range(0, 99));
      ph = m_mode[d] == 1 ? m_ph[d] : 0;
      rr = 3'($urandom);
      r = k < 55 ? lamp(ph) : k < 85 ? lamp(ph + 1) : k < 93 ? rr : lamp(ph + 2);
      step(r, (m_mode[d] == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 49) == 0,
           $urandom_range(0, 199) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
